// File: rtl/iter_mul.sv
// Radix-2 shift-add 32x32 multiplier for the EX-stage HI/LO path.
// Signed operands are reduced to magnitudes, multiplied over 32 cycles, and the sign is restored on completion.
`timescale 1ns/1ps

module iter_mul (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mul_signed,
  input  logic [31:0] ina,
  input  logic [31:0] inb,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] prod_q, prod_d;
  logic [63:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        ready_q, ready_d;

  logic [31:0] a_mag, b_mag;
  logic [32:0] sum;
  logic [63:0] prod_next;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    a_mag     = (mul_signed && ina[31]) ? (~ina + 32'd1) : ina;
    b_mag     = (mul_signed && inb[31]) ? (~inb + 32'd1) : inb;
    sum       = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    prod_next = {sum, prod_q[31:1]};
  end

  // NOTE: every next-state signal gets a hold default first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    ready_d  = ready_q;

    unique case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          mcand_d = a_mag;
          neg_d   = mul_signed & (ina[31] ^ inb[31]);
          if (ina == 32'd0 || inb == 32'd0) begin
            state_d  = DONE;
            result_d = 64'd0;
            ready_d  = 1'b1;
          end else begin
            prod_d  = {32'd0, b_mag};
            cnt_d   = 5'd0;
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        if (annul_i || !start_i) begin
          state_d = IDLE;
        end else begin
          prod_d = prod_next;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = neg_q ? (~prod_next + 64'd1) : prod_next;
          end
        end
      end

      DONE: begin
        if (annul_i || !start_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end
      end

      default: begin
        state_d  = IDLE;
        ready_d  = 1'b0;
        result_d = 64'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      mcand_q  <= 32'd0;
      prod_q   <= 64'd0;
      result_q <= 64'd0;
      cnt_q    <= 5'd0;
      neg_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_iter_mul.sv
// Self-checking bench for iter_mul: directed corner cases plus randomized products
// checked against a plain 64-bit arithmetic reference.
`timescale 1ns/1ps

module tb_iter_mul;

  logic        clk;
  logic        resetn;
  logic        mul_signed;
  logic [31:0] ina;
  logic [31:0] inb;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp = 0;
  int n_mis = 0;

  iter_mul dut (
    .clk        (clk),
    .resetn     (resetn),
    .mul_signed (mul_signed),
    .ina        (ina),
    .inb        (inb),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sign- or zero-extend to 64 bits, multiply modulo 2^64.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] ax, bx;
    ax = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    bx = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ax * bx;
  endfunction

  // One full EX-style transaction: start, wait for ready, optionally hold, drop start.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp, input int hold, input string tag);
    int          lat;
    int          exp_lat;
    logic        leak;
    exp_lat = (a == 32'd0 || b == 32'd0) ? 1 : 33;
    leak    = 1'b0;
    ina = a; inb = b; mul_signed = sgn; start_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (ready_o !== 1'b1 && result_o !== 64'd0) leak = 1'b1;
      ina = $urandom; inb = $urandom; mul_signed = 1'($urandom_range(0, 1));
    end while (ready_o !== 1'b1 && lat < 200);

    n_cmp++;
    if (lat !== exp_lat) begin
      n_mis++;
      $display("FAIL %s latency: got %0d cycles, want %0d", tag, lat, exp_lat);
    end
    n_cmp++;
    if (result_o !== exp) begin
      n_mis++;
      $display("FAIL %s result: got %h, want %h", tag, result_o, exp);
    end
    n_cmp++;
    if (leak !== 1'b0) begin
      n_mis++;
      $display("FAIL %s result_nonzero_before_ready: got %b, want 0", tag, leak);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ready_o !== 1'b1 || result_o !== exp) begin
        n_mis++;
        $display("FAIL %s hold%0d: got ready=%b result=%h, want ready=1 result=%h", tag, i, ready_o, result_o, exp);
      end
    end
    start_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_mis++;
      $display("FAIL %s after_drop: got ready=%b result=%h, want ready=0 result=0", tag, ready_o, result_o);
    end
  endtask

  // Watch ready_o for a window of cycles; it must never rise.
  task automatic expect_quiet(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ready_o !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_mis++;
      $display("FAIL %s quiet: got ready high in %0d cycles, want 0", tag, seen);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    mul_signed = 1'b0; ina = 32'd0; inb = 32'd0;
    #1;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_mis++;
      $display("FAIL reset_state: got ready=%b result=%h, want ready=0 result=0", ready_o, result_o);
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, "unsigned_max");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 0, "signed_m1_m1");
  endtask

  task automatic test_signed();
    run_op(32'hFFFF_FFFD, 32'd7,        1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0, "signed_m3_7");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, "signed_min_min");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 0, "unsigned_min_min");
    run_op(32'd7,         32'hFFFF_FFFD, 1'b0, 64'h0000_0006_FFFF_FFEB, 0, "unsigned_7_big");
  endtask

  task automatic test_zero();
    run_op(32'd0,         32'h0000_1234, 1'b0, 64'd0, 0, "zero_a_unsigned");
    run_op(32'd0,         32'h0000_1234, 1'b1, 64'd0, 0, "zero_a_signed");
    run_op(32'h8765_4321, 32'd0,         1'b1, 64'd0, 1, "zero_b_signed");
  endtask

  task automatic test_abort();
    ina = 32'h1234_5678; inb = 32'h9ABC_DEF0; mul_signed = 1'b0; start_i = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    expect_quiet(40, "annul_busy");
    annul_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    run_op(32'd5, 32'd6, 1'b0, 64'h1E, 0, "after_annul");

    ina = 32'd7; inb = 32'd9; start_i = 1'b1;
    repeat (5) @(negedge clk);
    start_i = 1'b0;
    expect_quiet(40, "start_drop_busy");
  endtask

  task automatic test_annul_done();
    int guard;
    ina = 32'd3; inb = 32'd4; mul_signed = 1'b0; start_i = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (ready_o !== 1'b1 && guard < 200);
    annul_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || guard !== 33) begin
      n_mis++;
      $display("FAIL annul_done: got ready=%b result=%h lat=%0d, want ready=0 result=0 lat=33", ready_o, result_o, guard);
    end
    annul_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold();
    run_op(32'hCAFE_F00D, 32'h0000_0003, 1'b1, model(32'hCAFE_F00D, 32'h3, 1'b1), 3, "hold_done");
  endtask

  task automatic test_async_reset();
    int guard;
    ina = 32'hDEAD_BEEF; inb = 32'h0000_1234; mul_signed = 1'b0; start_i = 1'b1;
    repeat (10) @(negedge clk);
    #2 resetn = 1'b0; start_i = 1'b0;
    #1;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_mis++;
      $display("FAIL async_reset_busy: got ready=%b result=%h, want 0/0", ready_o, result_o);
    end
    @(negedge clk);
    resetn = 1'b1;
    expect_quiet(40, "after_reset_busy");

    ina = 32'd11; inb = 32'd13; start_i = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (ready_o !== 1'b1 && guard < 200);
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_mis++;
      $display("FAIL async_reset_done: got ready=%b result=%h, want 0/0", ready_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 64'h0000_0000_FFFE_0001, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        sgn;
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      b   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: a = 32'd0;
        1: b = 32'd0;
        2: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(a, b, sgn, model(a, b, sgn), $urandom_range(0, 2), $sformatf("random%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_zero();
    test_abort();
    test_annul_done();
    test_hold();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
